spi_adapter_rr_arbiter: RTL and testbench

//  Shares one SPI minion adapter between NREQ core-side requesters.

---
 rtl/spi_arb_pkg.sv | 20 ++
 rtl/spi_arb_pipe_reg.sv | 34 +++
 rtl/spi_adapter_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_spi_adapter_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared widths, defaults and the upstream message layout for the SPI adapter arbiter.
package spi_arb_pkg;

  localparam int PERF_CNT_W = 16;
  localparam int DEF_MSG_W  = 6;
  localparam int DEF_NREQ   = 4;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_IDX_W = idx_w(DEF_NREQ);
  localparam int DEF_REQ_W = DEF_MSG_W - DEF_IDX_W;

  typedef struct packed {
    logic [DEF_IDX_W-1:0] tag;
    logic [DEF_REQ_W-1:0] data;
  } up_msg_t;

endpackage

// File: rtl/spi_arb_pipe_reg.sv
// One-entry registered val/rdy stage; a new word may load in the same cycle the old one drains.
module spi_arb_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_loadVal,
  output logic         o_loadRdy,
  input  logic [W-1:0] i_loadData,
  output logic         o_outVal,
  input  logic         i_outRdy,
  output logic [W-1:0] o_outData
);

  logic         r_full;
  logic [W-1:0] r_data;

  assign o_loadRdy = ~r_full | i_outRdy;
  assign o_outVal  = r_full;
  assign o_outData = r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_loadVal && o_loadRdy) begin
      r_full <= 1'b1;
      r_data <= i_loadData;
    end else if (i_outRdy) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_adapter_rr_arbiter.sv
// Round-robin share of one SPI minion adapter among NREQ requesters, tag-routed responses.
// Optional SPI_ARB_PERF_EN adds saturating grant/drop counters.
module spi_adapter_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int MSG_W = DEF_MSG_W
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NREQ-1:0]                      req_val,
  output logic [NREQ-1:0]                      req_rdy,
  input  logic [NREQ*(MSG_W-idx_w(NREQ))-1:0]  req_msg,
  output logic                                 adp_recv_val,
  input  logic                                 adp_recv_rdy,
  output logic [MSG_W-1:0]                     adp_recv_msg,
  input  logic                                 adp_send_val,
  output logic                                 adp_send_rdy,
  input  logic [MSG_W-1:0]                     adp_send_msg,
  output logic [NREQ-1:0]                      resp_val,
  input  logic [NREQ-1:0]                      resp_rdy,
  output logic [MSG_W-idx_w(NREQ)-1:0]         resp_msg
`ifdef SPI_ARB_PERF_EN
  ,
  output logic [NREQ*PERF_CNT_W-1:0]           grant_cnt,
  output logic [PERF_CNT_W-1:0]                drop_cnt
`endif
);

  localparam int IDX_W = idx_w(NREQ);
  localparam int REQ_W = MSG_W - IDX_W;

  logic [IDX_W-1:0] r_rrPtr;
  logic             w_canLoad;
  logic             w_found;
  logic [IDX_W-1:0] w_gIdx;
  int               w_idx;
  logic [MSG_W-1:0] w_upData;
  logic [IDX_W-1:0] w_sendTag;
  logic             w_tagOk;
  logic             w_dnFull;
  logic [MSG_W-1:0] w_dnData;
  logic [IDX_W-1:0] w_dnTag;
  logic             w_dnDrain;

  // Search starts at the pointer and wraps at NREQ, not at 2^IDX_W.
  always_comb begin
    w_found = 1'b0;
    w_gIdx  = '0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_rrPtr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && req_val[IDX_W'(w_idx)]) begin
        w_found = 1'b1;
        w_gIdx  = IDX_W'(w_idx);
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    if (w_canLoad && w_found) req_rdy[w_gIdx] = 1'b1;
  end

  assign w_upData = {w_gIdx, req_msg[w_gIdx*REQ_W +: REQ_W]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rrPtr <= '0;
    end else if (w_canLoad && w_found) begin
      r_rrPtr <= (w_gIdx == IDX_W'(NREQ-1)) ? '0 : w_gIdx + IDX_W'(1);
    end
  end

  spi_arb_pipe_reg #(.W(MSG_W)) u_upReg (
    .clk        (clk),
    .reset      (reset),
    .i_loadVal  (w_found),
    .o_loadRdy  (w_canLoad),
    .i_loadData (w_upData),
    .o_outVal   (adp_recv_val),
    .i_outRdy   (adp_recv_rdy),
    .o_outData  (adp_recv_msg)
  );

  // Out-of-range tags are still handshaked so the adapter never stalls on them.
  assign w_sendTag = adp_send_msg[MSG_W-1 -: IDX_W];
  assign w_tagOk   = ({1'b0, w_sendTag} < (IDX_W+1)'(NREQ));

  spi_arb_pipe_reg #(.W(MSG_W)) u_dnReg (
    .clk        (clk),
    .reset      (reset),
    .i_loadVal  (adp_send_val & w_tagOk),
    .o_loadRdy  (adp_send_rdy),
    .i_loadData (adp_send_msg),
    .o_outVal   (w_dnFull),
    .i_outRdy   (w_dnDrain),
    .o_outData  (w_dnData)
  );

  assign w_dnTag   = w_dnData[MSG_W-1 -: IDX_W];
  assign resp_msg  = w_dnData[REQ_W-1:0];
  assign w_dnDrain = |(resp_val & resp_rdy);

  always_comb begin
    resp_val = '0;
    if (w_dnFull) resp_val[w_dnTag] = 1'b1;
  end

`ifdef SPI_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] r_grantCnt [NREQ];
  logic [PERF_CNT_W-1:0] r_dropCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) r_grantCnt[i] <= '0;
      r_dropCnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_rdy[i] && r_grantCnt[i] != '1) r_grantCnt[i] <= r_grantCnt[i] + PERF_CNT_W'(1);
      end
      if (adp_send_val && adp_send_rdy && !w_tagOk && r_dropCnt != '1) begin
        r_dropCnt <= r_dropCnt + PERF_CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_grantCnt
    assign grant_cnt[i*PERF_CNT_W +: PERF_CNT_W] = r_grantCnt[i];
  end
  assign drop_cnt = r_dropCnt;
`endif

endmodule

// File: tb/tb_spi_adapter_rr_arbiter.sv
// Self-checking bench for spi_adapter_rr_arbiter: vector table, directed corners, random scoreboard.
module tb_spi_adapter_rr_arbiter;
  import spi_arb_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  reqVal, reqRdy, respVal, respRdy;
  logic [15:0] reqMsg;
  logic        recvVal, recvRdy, sendVal, sendRdy;
  logic [5:0]  recvMsg, sendMsg;
  logic [3:0]  respMsg;

  logic [2:0]  reqVal3, reqRdy3, respVal3, respRdy3;
  logic [11:0] reqMsg3;
  logic        recvVal3, recvRdy3, sendVal3, sendRdy3;
  logic [5:0]  recvMsg3, sendMsg3;
  logic [3:0]  respMsg3;

`ifdef SPI_ARB_PERF_EN
  logic [63:0] grantCnt;
  logic [15:0] dropCnt;
  logic [47:0] grantCnt3;
  logic [15:0] dropCnt3;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] rv;
    logic       rdy;
    logic [3:0] expRdy;
    logic       expVal;
    logic [5:0] expMsg;
  } vec_t;
  vec_t vecs [13];

  up_msg_t    upQ [$];
  logic [5:0] dnQ [$];
  int         mPtr, g, idx;
  int         waitCnt [4];
  logic       expSendRdy;

  spi_adapter_rr_arbiter #(.NREQ(4), .MSG_W(6)) u_dut (
    .clk(clk), .reset(reset),
    .req_val(reqVal), .req_rdy(reqRdy), .req_msg(reqMsg),
    .adp_recv_val(recvVal), .adp_recv_rdy(recvRdy), .adp_recv_msg(recvMsg),
    .adp_send_val(sendVal), .adp_send_rdy(sendRdy), .adp_send_msg(sendMsg),
    .resp_val(respVal), .resp_rdy(respRdy), .resp_msg(respMsg)
`ifdef SPI_ARB_PERF_EN
    , .grant_cnt(grantCnt), .drop_cnt(dropCnt)
`endif
  );

  spi_adapter_rr_arbiter #(.NREQ(3), .MSG_W(6)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_val(reqVal3), .req_rdy(reqRdy3), .req_msg(reqMsg3),
    .adp_recv_val(recvVal3), .adp_recv_rdy(recvRdy3), .adp_recv_msg(recvMsg3),
    .adp_send_val(sendVal3), .adp_send_rdy(sendRdy3), .adp_send_msg(sendMsg3),
    .resp_val(respVal3), .resp_rdy(respRdy3), .resp_msg(respMsg3)
`ifdef SPI_ARB_PERF_EN
    , .grant_cnt(grantCnt3), .drop_cnt(dropCnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] rv, input logic rdy);
    reqVal  = rv;
    recvRdy = rdy;
    #1;
  endtask

  initial begin
    reqVal = '0; reqMsg = 16'h4A21; recvRdy = 1'b0;
    sendVal = 1'b0; sendMsg = '0; respRdy = '0;
    reqVal3 = '0; reqMsg3 = 12'h321; recvRdy3 = 1'b0;
    sendVal3 = 1'b0; sendMsg3 = '0; respRdy3 = '0;

    vecs[0]  = '{4'hF, 1'b1, 4'h1, 1'b1, 6'h01};
    vecs[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 6'h12};
    vecs[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 6'h2A};
    vecs[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 6'h34};
    vecs[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 6'h01};
    vecs[5]  = '{4'h4, 1'b1, 4'h4, 1'b1, 6'h2A};
    vecs[6]  = '{4'hF, 1'b0, 4'h0, 1'b1, 6'h2A};
    vecs[7]  = '{4'hF, 1'b0, 4'h0, 1'b1, 6'h2A};
    vecs[8]  = '{4'hF, 1'b0, 4'h0, 1'b1, 6'h2A};
    vecs[9]  = '{4'h0, 1'b1, 4'h0, 1'b0, 6'h00};
    vecs[10] = '{4'h1, 1'b1, 4'h1, 1'b1, 6'h01};
    vecs[11] = '{4'hA, 1'b1, 4'h2, 1'b1, 6'h12};
    vecs[12] = '{4'h9, 1'b1, 4'h8, 1'b1, 6'h34};

    reset = 1'b1;
    repeat (2) stepClock();
    checkOutput("reset recv_val", recvVal, 0);
    checkOutput("reset resp_val", respVal, 0);
    checkOutput("reset req_rdy", reqRdy, 0);
    reset = 1'b0;
    #1;
    checkOutput("reset send_rdy", sendRdy, 1);
    stepClock();

    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v].rv, vecs[v].rdy);
      checkOutput($sformatf("vec%0d req_rdy", v), reqRdy, vecs[v].expRdy);
      stepClock();
      checkOutput($sformatf("vec%0d recv_val", v), recvVal, vecs[v].expVal);
      if (vecs[v].expVal) checkOutput($sformatf("vec%0d recv_msg", v), recvMsg, vecs[v].expMsg);
    end
    applyStimulus(4'h0, 1'b1);
    stepClock();

    // Response held while its requester back-pressures.
    sendVal = 1'b1; sendMsg = 6'b01_0111; respRdy = 4'b0000;
    #1;
    checkOutput("dn empty send_rdy", sendRdy, 1);
    stepClock();
    sendVal = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checkOutput("dn hold resp_val", respVal, 4'b0010);
      checkOutput("dn hold resp_msg", respMsg, 4'h7);
      checkOutput("dn hold send_rdy", sendRdy, 0);
      stepClock();
    end
    respRdy = 4'b0010;
    #1;
    checkOutput("dn drain send_rdy", sendRdy, 1);
    stepClock();
    checkOutput("dn drained resp_val", respVal, 0);
    respRdy = 4'b0000;

    // NREQ=3: bad tag dropped, good tag routed, pointer wraps at 3.
    sendVal3 = 1'b1; sendMsg3 = 6'b11_0101;
    #1;
    checkOutput("n3 bad tag send_rdy", sendRdy3, 1);
    stepClock();
    checkOutput("n3 bad tag resp_val", respVal3, 0);
    checkOutput("n3 after drop send_rdy", sendRdy3, 1);
    sendMsg3 = 6'b10_0110;
    stepClock();
    sendVal3 = 1'b0;
    checkOutput("n3 tag2 resp_val", respVal3, 3'b100);
    checkOutput("n3 tag2 resp_msg", respMsg3, 4'h6);
    respRdy3 = 3'b100;
    stepClock();
    checkOutput("n3 drained resp_val", respVal3, 0);
`ifdef SPI_ARB_PERF_EN
    checkOutput("n3 drop_cnt", dropCnt3, 1);
`endif
    reqVal3 = 3'b111; recvRdy3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("n3 rr%0d req_rdy", k), reqRdy3, 32'd1 << (k % 3));
      stepClock();
      checkOutput($sformatf("n3 rr%0d recv_msg", k), recvMsg3, {2'(k % 3), 4'(k % 3 + 1)});
    end
    reqVal3 = '0;

    // Reset with both buffers full and the pointer at 2.
    reset = 1'b1; stepClock(); reset = 1'b0;
    applyStimulus(4'h3, 1'b1); stepClock();
    applyStimulus(4'h2, 1'b1); stepClock();
    applyStimulus(4'h0, 1'b0); stepClock();
    checkOutput("pre-reset recv_val", recvVal, 1);
    sendVal = 1'b1; sendMsg = 6'b00_0101; respRdy = 4'b0000;
    stepClock();
    sendVal = 1'b0;
    checkOutput("pre-reset resp_val", respVal, 4'b0001);
    reset = 1'b1;
    stepClock();
    checkOutput("mid-reset recv_val", recvVal, 0);
    checkOutput("mid-reset resp_val", respVal, 0);
    reset = 1'b0;
    applyStimulus(4'hF, 1'b1);
    checkOutput("post-reset req_rdy", reqRdy, 4'b0001);

    // Random stress against a queue-based reference model.
    reset = 1'b1; stepClock(); reset = 1'b0;
    mPtr = 0;
    for (int i = 0; i < 4; i++) waitCnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      reqVal  = 4'($urandom);
      reqMsg  = 16'($urandom);
      recvRdy = ($urandom_range(3) != 0);
      sendVal = 1'($urandom);
      sendMsg = 6'($urandom);
      respRdy = 4'($urandom);
      #1;
      checkOutput("rnd recv_val", recvVal, upQ.size() != 0);
      if (upQ.size() != 0) checkOutput("rnd recv_msg", recvMsg, upQ[0]);
      g = -1;
      if (upQ.size() == 0 || recvRdy) begin
        for (int k = 0; k < 4; k++) begin
          idx = (mPtr + k) % 4;
          if (g < 0 && reqVal[idx]) g = idx;
        end
      end
      checkOutput("rnd req_rdy", reqRdy, (g >= 0) ? (32'd1 << g) : 32'd0);
      if (upQ.size() != 0 && recvRdy) void'(upQ.pop_front());
      if (g >= 0) begin
        upQ.push_back(up_msg_t'{tag: 2'(g), data: reqMsg[g*4 +: 4]});
        mPtr = (g + 1) % 4;
      end
      for (int i = 0; i < 4; i++) begin
        if (!reqVal[i] || g == i) waitCnt[i] = 0;
        else if (g >= 0) begin
          waitCnt[i]++;
          checkOutput("rnd fairness", waitCnt[i] <= 3, 1);
        end
      end

      expSendRdy = (dnQ.size() == 0) || respRdy[dnQ[0][5:4]];
      checkOutput("rnd send_rdy", sendRdy, expSendRdy);
      checkOutput("rnd resp_val", respVal, (dnQ.size() != 0) ? (32'd1 << dnQ[0][5:4]) : 32'd0);
      if (dnQ.size() != 0) checkOutput("rnd resp_msg", respMsg, dnQ[0][3:0]);
      if (dnQ.size() != 0 && respRdy[dnQ[0][5:4]]) void'(dnQ.pop_front());
      if (sendVal && expSendRdy) dnQ.push_back(sendMsg);
      stepClock();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
